cmd_q: RTL and testbench

Command queue at the DRAM-facing end of the memory controller's issue path. Accepts one issued command per cycle (`valid`/`rw`/`adrs_in`) from the controller top, buffers it in a FIFO, and raises `busy` back to the controller as the queue fills. Drains commands to the PHY/command bus through a valid/ready handshake. Pop spacing follows a minimum command-to-command gap (`t_ccd`) and a longer gap on read/write direction change (`t_turn`).

---
 rtl/cmd_q.sv | 99 +++++++++
 tb/tb_cmd_q.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_q.sv
// Command queue between the controller issue path and the PHY command bus.
// Buffers {rw, adrs} commands and spaces pops by t_ccd, or by t_turn on direction change.
module cmd_q #(
   parameter int depth   = 8,
   parameter int aw      = 3,
   parameter int busy_th = 6,
   parameter int t_ccd   = 4,
   parameter int t_turn  = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid,
   input  logic          rw,
   input  logic [31:0]   adrs_in,
   output logic          busy,
   output logic          cmd_valid,
   output logic          cmd_rw,
   output logic [31:0]   cmd_adrs,
   input  logic          cmd_ready,
   output logic [aw:0]   count,
   output logic          ovf
);

   localparam int              cw       = $clog2(t_turn) + 1;
   localparam logic [aw:0]     full_cnt = (aw+1)'(depth);
   localparam logic [aw:0]     busy_cnt = (aw+1)'(busy_th);
   localparam logic [cw-1:0]   gap_ld   = cw'(t_ccd - 1);
   localparam logic [cw-1:0]   turn_ld  = cw'(t_turn - 1);

   logic [32:0]   r_mem [depth];
   logic [aw-1:0] r_wptr;
   logic [aw-1:0] r_rptr;
   logic [aw:0]   r_count;
   logic [cw-1:0] r_gap;
   logic [cw-1:0] r_turn;
   logic          r_last_rw;
   logic          r_last_vld;
   logic          r_ovf;

   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic          w_dir_ok;
   logic [32:0]   w_head;

   // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
   assign w_full    = (r_count == full_cnt);
   assign w_push    = valid && !w_full;
   assign w_pop     = cmd_valid && cmd_ready;
   assign w_head    = r_mem[r_rptr];
   assign w_dir_ok  = !r_last_vld || (w_head[32] == r_last_rw) || (r_turn == '0);

   assign cmd_valid = (r_count != '0) && (r_gap == '0) && w_dir_ok;
   assign cmd_rw    = w_head[32];
   assign cmd_adrs  = w_head[31:0];
   assign busy      = (r_count >= busy_cnt);
   assign count     = r_count;
   assign ovf       = r_ovf;

   // NOTE: storage has no reset; the count and pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= {rw, adrs_in};
   end

   // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_gap      <= '0;
         r_turn     <= '0;
         r_last_rw  <= 1'b0;
         r_last_vld <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + aw'(1);
         if (w_pop)  r_rptr <= r_rptr + aw'(1);
         if (valid && w_full) r_ovf <= 1'b1;

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (aw+1)'(1);
            2'b01:   r_count <= r_count - (aw+1)'(1);
            default: r_count <= r_count;
         endcase

         if (w_pop) begin
            r_gap      <= gap_ld;
            r_turn     <= turn_ld;
            r_last_rw  <= w_head[32];
            r_last_vld <= 1'b1;
         end else begin
            if (r_gap != '0)  r_gap  <= r_gap - cw'(1);
            if (r_turn != '0) r_turn <= r_turn - cw'(1);
         end
      end
   end

endmodule

// File: tb/tb_cmd_q.sv
// Self-checking bench for cmd_q: a queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_cmd_q;

   localparam int DEPTH   = 8;
   localparam int AW      = 3;
   localparam int BUSY_TH = 6;
   localparam int T_CCD   = 4;
   localparam int T_TURN  = 8;

   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic          valid     = 1'b0;
   logic          rw        = 1'b0;
   logic [31:0]   adrs_in   = '0;
   logic          cmd_ready = 1'b0;
   logic          busy;
   logic          cmd_valid;
   logic          cmd_rw;
   logic [31:0]   cmd_adrs;
   logic [AW:0]   count;
   logic          ovf;

   cmd_q #(
      .depth(DEPTH), .aw(AW), .busy_th(BUSY_TH), .t_ccd(T_CCD), .t_turn(T_TURN)
   ) dut (
      .clk(clk), .rst(rst), .valid(valid), .rw(rw), .adrs_in(adrs_in),
      .busy(busy), .cmd_valid(cmd_valid), .cmd_rw(cmd_rw), .cmd_adrs(cmd_adrs),
      .cmd_ready(cmd_ready), .count(count), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic rw; logic [31:0] adrs; } ent_t;
   typedef struct { int cyc; logic rw; logic [31:0] adrs; } pop_t;

   int     n_chk = 0;
   int     n_err = 0;

   // Reference model: a plain queue plus the cycle and direction of the most recent pop.
   ent_t   m_q[$];
   bit     m_init     = 1'b0;
   bit     m_last_vld = 1'b0;
   logic   m_last_rw  = 1'b0;
   int     m_last_cyc = 0;
   bit     m_ovf      = 1'b0;
   int     cyc        = 0;
   pop_t   dut_log[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit m_cv();
      int d;
      if (m_q.size() == 0) return 1'b0;
      if (!m_last_vld) return 1'b1;
      d = cyc - m_last_cyc;
      if (d < T_CCD) return 1'b0;
      if (m_q[0].rw == m_last_rw) return 1'b1;
      return d >= T_TURN;
   endfunction

   always @(posedge clk) begin
      ent_t e;
      bit   full;
      if (m_init && !rst && cmd_valid === 1'b1 && cmd_ready)
         dut_log.push_back('{cyc, cmd_rw, cmd_adrs});
      if (rst) begin
         m_q.delete();
         m_last_vld = 1'b0;
         m_last_rw  = 1'b0;
         m_ovf      = 1'b0;
         m_init     = 1'b1;
      end else if (m_init) begin
         full = (m_q.size() == DEPTH);
         if (m_cv() && cmd_ready) begin
            e          = m_q.pop_front();
            m_last_cyc = cyc;
            m_last_rw  = e.rw;
            m_last_vld = 1'b1;
         end
         if (valid) begin
            if (full) m_ovf = 1'b1;
            else      m_q.push_back('{rw, adrs_in});
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (m_init) begin
         check("count", 64'(count), 64'(m_q.size()));
         check("busy", 64'(busy), 64'(m_q.size() >= BUSY_TH));
         check("ovf", 64'(ovf), 64'(m_ovf));
         check("cmd_valid", 64'(cmd_valid), 64'(m_cv()));
         if (m_q.size() != 0) begin
            check("cmd_rw", 64'(cmd_rw), 64'(m_q[0].rw));
            check("cmd_adrs", 64'(cmd_adrs), 64'(m_q[0].adrs));
         end
      end
   end

   task automatic cyc_step(input logic v, input logic r, input logic [31:0] a, input logic rdy);
      @(negedge clk);
      valid     = v;
      rw        = r;
      adrs_in   = a;
      cmd_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int g;
      int k;
      logic [31:0] exp_a [9];

      // Reset then idle
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_count", 64'(count), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);

      // Fill with writes 0x100..0x108; the ninth is dropped
      for (int i = 0; i < 9; i++) begin
         cyc_step(1'b1, 1'b0, 32'h100 + 32'(i), 1'b0);
         check("fill_count", 64'(count), 64'((i < 8) ? i + 1 : 8));
         check("fill_busy", 64'(busy), 64'(i + 1 >= 6));
         check("fill_ovf", 64'(ovf), 64'(i == 8));
      end

      // Same-direction drain: pops every 4 cycles, in order
      dut_log.delete();
      g = 0;
      while (dut_log.size() < 8 && g < 100) begin
         cyc_step(1'b0, 1'b0, 32'h0, 1'b1);
         g++;
      end
      check("drain_pops", 64'(dut_log.size()), 64'd8);
      for (int i = 0; i < dut_log.size() && i < 8; i++) begin
         check("drain_adrs", 64'(dut_log[i].adrs), 64'(32'h100 + 32'(i)));
         if (i > 0) check("drain_spacing", 64'(dut_log[i].cyc - dut_log[i-1].cyc), 64'd4);
      end

      // Turnaround: W 0x10, R 0x20, R 0x24 -> pops at c, c+8, c+12
      cyc_step(1'b1, 1'b0, 32'h10, 1'b0);
      cyc_step(1'b1, 1'b1, 32'h20, 1'b0);
      cyc_step(1'b1, 1'b1, 32'h24, 1'b0);
      repeat (12) cyc_step(1'b0, 1'b0, 32'h0, 1'b0);
      dut_log.delete();
      g = 0;
      while (dut_log.size() < 3 && g < 60) begin
         cyc_step(1'b0, 1'b0, 32'h0, 1'b1);
         g++;
      end
      check("turn_pops", 64'(dut_log.size()), 64'd3);
      if (dut_log.size() == 3) begin
         check("turn_adrs0", 64'(dut_log[0].adrs), 64'h10);
         check("turn_adrs1", 64'(dut_log[1].adrs), 64'h20);
         check("turn_adrs2", 64'(dut_log[2].adrs), 64'h24);
         check("turn_gap_wr", 64'(dut_log[1].cyc - dut_log[0].cyc), 64'd8);
         check("turn_gap_rr", 64'(dut_log[2].cyc - dut_log[1].cyc), 64'd4);
      end

      // Simultaneous push and pop at count 3, wrapping the pointers past entry 7
      for (int i = 0; i < 3; i++) cyc_step(1'b1, 1'b0, 32'h200 + 32'(i), 1'b0);
      dut_log.delete();
      k = 0;
      g = 0;
      while (k < 6 && g < 200) begin
         if (m_cv()) begin
            cyc_step(1'b1, 1'b0, 32'h300 + 32'(k), 1'b1);
            check("simul_count", 64'(count), 64'd3);
            k++;
         end else begin
            cyc_step(1'b0, 1'b0, 32'h0, 1'b0);
         end
         g++;
      end
      while (dut_log.size() < 9 && g < 300) begin
         cyc_step(1'b0, 1'b0, 32'h0, 1'b1);
         g++;
      end
      exp_a = '{32'h200, 32'h201, 32'h202, 32'h300, 32'h301, 32'h302, 32'h303, 32'h304, 32'h305};
      check("simul_pops", 64'(dut_log.size()), 64'd9);
      for (int i = 0; i < dut_log.size() && i < 9; i++)
         check("simul_order", 64'(dut_log[i].adrs), 64'(exp_a[i]));

      // Reset mid-drain with count 5 and the gap counter running
      for (int i = 0; i < 6; i++) cyc_step(1'b1, 1'b0, 32'h500 + 32'(i), 1'b0);
      repeat (10) cyc_step(1'b0, 1'b0, 32'h0, 1'b0);
      cyc_step(1'b0, 1'b0, 32'h0, 1'b1);
      check("pre_rst_count", 64'(count), 64'd5);
      @(negedge clk);
      rst       = 1'b1;
      cmd_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid_rst_count", 64'(count), 64'd0);
      check("mid_rst_cmd_valid", 64'(cmd_valid), 64'd0);
      check("mid_rst_ovf", 64'(ovf), 64'd0);
      cyc_step(1'b1, 1'b1, 32'h400, 1'b0);
      check("post_rst_cmd_valid", 64'(cmd_valid), 64'd1);
      check("post_rst_adrs", 64'(cmd_adrs), 64'h400);
      check("post_rst_rw", 64'(cmd_rw), 64'd1);

      // Randomized soak against the model
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rst       = ($urandom_range(0, 199) == 0);
         valid     = ($urandom_range(0, 9) < 6);
         rw        = 1'($urandom_range(0, 1));
         adrs_in   = $urandom;
         cmd_ready = ($urandom_range(0, 9) < 5);
      end
      @(negedge clk);
      rst       = 1'b0;
      valid     = 1'b0;
      cmd_ready = 1'b0;
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
